// File: rtl/reg_lock_tracker.sv
// Register-lock scoreboard: per-register outstanding-writer counters, a blocking
// mode that locks everything, and a memory-busy flag. All outputs are registered.
module reg_lock_tracker #(
    parameter int NR  = 64,
    parameter int NWB = 2,
    parameter int CW  = 2
) (
    input  logic                      clk_i,
    input  logic                      arst_ni,
    input  logic                      issue_valid_i,
    input  logic [$clog2(NR)-1:0]     issue_rd_i,
    input  logic                      issue_blocking_i,
    input  logic                      issue_mem_op_i,
    input  logic [NWB-1:0]            wb_valid_i,
    input  logic [NWB*$clog2(NR)-1:0] wb_rd_i,
    input  logic                      blk_done_i,
    input  logic                      mem_done_i,
    output logic [NR-1:0]             locks_o,
    output logic                      mem_busy_o,
    output logic                      err_o
);

    localparam int RW = $clog2(NR);
    localparam int SW = CW + 2;
    localparam logic [CW-1:0] CMAX = '1;

    typedef enum logic {NORMAL, BLOCK} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q [NR];
    logic [CW-1:0]   cnt_d [NR];
    logic [SW-1:0]   sum;
    logic [NR-1:0]   locks_d;
    logic            busy_d;
    logic            err_d;
    logic            issue_ok;
    logic            mem_issue;

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) state_q <= NORMAL;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        err_d     = 1'b0;
        sum       = '0;
        cnt_d[0]  = '0;
        issue_ok  = issue_valid_i && (state_q == NORMAL);
        mem_issue = issue_ok && issue_mem_op_i;

        case (state_q)
            NORMAL: begin
                if (issue_valid_i && issue_blocking_i) state_d = BLOCK;
                if (blk_done_i) err_d = 1'b1;
            end
            BLOCK: begin
                if (issue_valid_i) err_d = 1'b1;
                if (blk_done_i) state_d = NORMAL;
            end
            default: state_d = NORMAL;
        endcase

        // Net +inc-dec is formed with two spare bits so that both overflow
        // (bit SW-2 set) and underflow (sign bit SW-1 set) are detectable.
        for (int unsigned r = 1; r < NR; r++) begin
            sum = SW'(cnt_q[r]);
            if (issue_ok && !issue_blocking_i && issue_rd_i == RW'(r))
                sum = sum + SW'(1);
            for (int unsigned k = 0; k < NWB; k++) begin
                if (wb_valid_i[k] && wb_rd_i[k*RW +: RW] == RW'(r))
                    sum = sum - SW'(1);
            end
            if (sum[SW-1]) begin
                cnt_d[r] = '0;
                err_d    = 1'b1;
            end else if (sum[SW-2:CW] != '0) begin
                cnt_d[r] = CMAX;
                err_d    = 1'b1;
            end else begin
                cnt_d[r] = sum[CW-1:0];
            end
        end

        busy_d = mem_issue || (mem_busy_o && !mem_done_i);
        if (mem_issue && mem_busy_o && !mem_done_i) err_d = 1'b1;
        if (mem_done_i && !mem_busy_o) err_d = 1'b1;

        for (int unsigned r = 0; r < NR; r++)
            locks_d[r] = (state_d == BLOCK) || (cnt_d[r] != '0);
    end

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            for (int unsigned r = 0; r < NR; r++) cnt_q[r] <= '0;
            locks_o    <= '0;
            mem_busy_o <= 1'b0;
            err_o      <= 1'b0;
        end else begin
            for (int unsigned r = 0; r < NR; r++) cnt_q[r] <= cnt_d[r];
            locks_o    <= locks_d;
            mem_busy_o <= busy_d;
            err_o      <= err_d;
        end
    end

endmodule

// File: tb/tb_reg_lock_tracker.sv
// Directed and closed-loop random checks of reg_lock_tracker against
// hand-computed lock vectors, memory-busy flag and error pulses.
module tb_reg_lock_tracker;

    logic        clk = 1'b0;
    logic        arst_ni;
    logic        issue_valid;
    logic [5:0]  issue_rd;
    logic        issue_blocking;
    logic        issue_mem_op;
    logic [1:0]  wb_valid;
    logic [11:0] wb_rd;
    logic        blk_done;
    logic        mem_done;
    logic [63:0] locks;
    logic        mem_busy;
    logic        err;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    reg_lock_tracker #(.NR(64), .NWB(2), .CW(2)) dut (
        .clk_i            (clk),
        .arst_ni          (arst_ni),
        .issue_valid_i    (issue_valid),
        .issue_rd_i       (issue_rd),
        .issue_blocking_i (issue_blocking),
        .issue_mem_op_i   (issue_mem_op),
        .wb_valid_i       (wb_valid),
        .wb_rd_i          (wb_rd),
        .blk_done_i       (blk_done),
        .mem_done_i       (mem_done),
        .locks_o          (locks),
        .mem_busy_o       (mem_busy),
        .err_o            (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic idle();
        issue_valid    = 1'b0;
        issue_rd       = '0;
        issue_blocking = 1'b0;
        issue_mem_op   = 1'b0;
        wb_valid       = '0;
        wb_rd          = '0;
        blk_done       = 1'b0;
        mem_done       = 1'b0;
    endtask

    task automatic issue(input int unsigned rd, input logic blk, input logic mem);
        issue_valid    = 1'b1;
        issue_rd       = 6'(rd);
        issue_blocking = blk;
        issue_mem_op   = mem;
    endtask

    task automatic wb(input int unsigned port, input int unsigned rd);
        wb_valid[port]       = 1'b1;
        wb_rd[port*6 +: 6]   = 6'(rd);
    endtask

    // Advance one clock edge, then sample 1 time unit later with inputs cleared.
    task automatic tick();
        @(posedge clk);
        #1;
        idle();
    endtask

    function automatic logic [63:0] bit_at(input int unsigned r);
        logic [63:0] v;
        v    = '0;
        v[r] = 1'b1;
        return v;
    endfunction

    logic [63:0] all_ones;
    logic [63:0] exp_lock;
    logic [63:0] picked;
    int unsigned rd, start, idx;
    logic        found;

    initial begin
        all_ones = '1;
        idle();
        arst_ni = 1'b0;
        #12;
        check("reset_locks", locks, '0);
        check("reset_busy", 64'(mem_busy), 0);
        check("reset_err", 64'(err), 0);
        @(negedge clk);
        arst_ni = 1'b1;
        @(posedge clk);
        #1;

        // single lock / release
        issue(5, 1'b0, 1'b0);
        tick();
        check("lock5", locks, bit_at(5));
        check("lock5_err", 64'(err), 0);
        wb(0, 5);
        tick();
        check("release5", locks, '0);
        check("release5_err", 64'(err), 0);

        // counting and saturation on rd=7
        repeat (3) begin
            issue(7, 1'b0, 1'b0);
            tick();
        end
        check("cnt7_3", locks, bit_at(7));
        check("cnt7_3_err", 64'(err), 0);
        issue(7, 1'b0, 1'b0);
        tick();
        check("sat7_err", 64'(err), 1);
        tick();
        check("sat7_err_pulse", 64'(err), 0);
        wb(0, 7);
        wb(1, 7);
        tick();
        check("dual_wb7", locks, bit_at(7));
        check("dual_wb7_err", 64'(err), 0);
        wb(1, 7);
        tick();
        check("clear7", locks, '0);
        check("clear7_err", 64'(err), 0);

        // issue and wb same register in one cycle
        issue(20, 1'b0, 1'b0);
        tick();
        issue(20, 1'b0, 1'b0);
        wb(0, 20);
        tick();
        check("same_cycle20", locks, bit_at(20));
        check("same_cycle20_err", 64'(err), 0);
        wb(1, 20);
        tick();
        check("clear20", locks, '0);

        // underflow and register zero
        wb(0, 30);
        tick();
        check("underflow_err", 64'(err), 1);
        check("underflow_locks", locks, '0);
        issue(0, 1'b0, 1'b0);
        wb(1, 0);
        tick();
        check("rd0_locks", locks, '0);
        check("rd0_err", 64'(err), 0);

        // blocking mode
        issue(9, 1'b0, 1'b0);
        tick();
        issue(3, 1'b1, 1'b0);
        tick();
        check("block_all", locks, all_ones);
        check("block_err", 64'(err), 0);
        issue(11, 1'b0, 1'b0);
        tick();
        check("issue_in_block_err", 64'(err), 1);
        check("issue_in_block_locks", locks, all_ones);
        wb(0, 9);
        tick();
        check("wb_in_block", locks, all_ones);
        check("wb_in_block_err", 64'(err), 0);
        blk_done = 1'b1;
        tick();
        check("blk_done_locks", locks, '0);
        check("blk_done_err", 64'(err), 0);
        blk_done = 1'b1;
        tick();
        check("blk_done_normal_err", 64'(err), 1);

        // memory-busy flag
        issue(12, 1'b0, 1'b1);
        tick();
        check("mem_busy_set", 64'(mem_busy), 1);
        check("mem_lock12", locks, bit_at(12));
        issue(0, 1'b0, 1'b1);
        mem_done = 1'b1;
        tick();
        check("mem_set_clear", 64'(mem_busy), 1);
        check("mem_set_clear_err", 64'(err), 0);
        issue(0, 1'b0, 1'b1);
        tick();
        check("mem_double_err", 64'(err), 1);
        check("mem_double_busy", 64'(mem_busy), 1);
        mem_done = 1'b1;
        tick();
        check("mem_clear", 64'(mem_busy), 0);
        check("mem_clear_err", 64'(err), 0);
        mem_done = 1'b1;
        tick();
        check("mem_idle_done_err", 64'(err), 1);
        wb(0, 12);
        tick();
        check("clear12", locks, '0);

        // reset mid-operation, between clock edges
        issue(40, 1'b1, 1'b1);
        tick();
        check("pre_reset_locks", locks, all_ones);
        #3;
        arst_ni = 1'b0;
        #1;
        check("midreset_locks", locks, '0);
        check("midreset_busy", 64'(mem_busy), 0);
        check("midreset_err", 64'(err), 0);
        @(negedge clk);
        arst_ni = 1'b1;
        tick();
        check("post_reset_locks", locks, '0);

        // closed loop: issue only unlocked registers, release outstanding ones
        exp_lock = '0;
        for (int cyc = 0; cyc < 1000; cyc++) begin
            picked = '0;
            for (int p = 0; p < 2; p++) begin
                if ($urandom_range(0, 2) != 0) begin
                    start = $urandom_range(1, 63);
                    found = 1'b0;
                    for (int j = 0; j < 63; j++) begin
                        idx = 1 + ((start - 1 + j) % 63);
                        if (!found && exp_lock[idx] && !picked[idx]) begin
                            found       = 1'b1;
                            picked[idx] = 1'b1;
                            wb(p, idx);
                        end
                    end
                end
            end
            exp_lock = exp_lock & ~picked;
            if ($urandom_range(0, 1) == 1) begin
                rd = $urandom_range(1, 63);
                if (!exp_lock[rd] && !picked[rd]) begin
                    issue(rd, 1'b0, 1'b0);
                    exp_lock[rd] = 1'b1;
                end
            end
            tick();
            check("loop_locks", locks, exp_lock);
            check("loop_err", 64'(err), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
